// File: rtl/midi_parser_pkg.sv
// Shared definitions for the MIDI byte-stream parser: message type codes,
// byte-class boundaries, FSM state encoding and byte classification helpers.
package midi_parser_pkg;

    // Channel-voice message types (status[6:4])
    typedef enum logic [2:0] {
        MSG_NOTE_OFF   = 3'd0,
        MSG_NOTE_ON    = 3'd1,
        MSG_POLY_AT    = 3'd2,
        MSG_CC         = 3'd3,
        MSG_PROG_CHG   = 3'd4,
        MSG_CHAN_AT    = 3'd5,
        MSG_PITCH_BEND = 3'd6
    } msg_type_t;

    // Parser states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2,
        ST_SYSEX   = 2'd3
    } state_t;

    // Byte-class boundaries
    localparam logic [7:0] BYTE_SYSEX_START = 8'hF0;
    localparam logic [7:0] BYTE_SYS_MIN     = 8'hF0;
    localparam logic [7:0] BYTE_RT_MIN      = 8'hF8;

    // 0xF8-0xFF: real-time, may interleave anywhere
    function automatic logic is_realtime(input logic [7:0] b);
        return b >= BYTE_RT_MIN;
    endfunction

    // 0xF1-0xF7: system common other than SysEx start
    function automatic logic is_syscommon(input logic [7:0] b);
        return (b > BYTE_SYS_MIN) && (b < BYTE_RT_MIN);
    endfunction

    // Program Change and Channel Aftertouch carry a single data byte
    function automatic logic needs_two(input msg_type_t t);
        return (t != MSG_PROG_CHG) && (t != MSG_CHAN_AT);
    endfunction

endpackage

// File: rtl/midi_parser.sv
// MIDI channel-voice message parser. Assembles messages from a received byte
// stream with running status, SysEx skipping, real-time passthrough and an
// optional channel filter; emits one registered strobe per complete message.
module midi_parser
    import midi_parser_pkg::*;
#(
    parameter logic       OMNI          = 1'b1,
    parameter logic [3:0] CHANNEL       = 4'd0,
    parameter logic       NOTEON_V0_OFF = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic       msg_valid,
    output logic [2:0] msg_type,
    output logic [3:0] msg_chan,
    output logic [6:0] msg_d1,
    output logic [6:0] msg_d2,
    output logic       rt_valid,
    output logic [7:0] rt_byte
);

    state_t    state;
    msg_type_t stat_type;
    logic [3:0] stat_chan;
    logic [6:0] d1_hold;

    msg_type_t  emit_type;
    logic [6:0] emit_d1;
    logic [6:0] emit_d2;
    logic       chan_ok;

    // Fields of the message that the current data byte would complete
    always_comb begin
        emit_d1   = byte_in[6:0];
        emit_d2   = '0;
        if (state == ST_WAIT_D2) begin
            emit_d1 = d1_hold;
            emit_d2 = byte_in[6:0];
        end
        emit_type = stat_type;
        if (NOTEON_V0_OFF && (stat_type == MSG_NOTE_ON) && (emit_d2 == '0))
            emit_type = MSG_NOTE_OFF;
        chan_ok   = OMNI || (stat_chan == CHANNEL);
    end

    // Parser FSM with registered message and real-time outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            stat_type <= MSG_NOTE_OFF;
            stat_chan <= '0;
            d1_hold   <= '0;
            msg_valid <= 1'b0;
            msg_type  <= '0;
            msg_chan  <= '0;
            msg_d1    <= '0;
            msg_d2    <= '0;
            rt_valid  <= 1'b0;
            rt_byte   <= '0;
        end else begin
            msg_valid <= 1'b0;
            rt_valid  <= 1'b0;
            if (byte_valid) begin
                if (is_realtime(byte_in)) begin
                    // Transparent: parser state is left untouched
                    rt_valid <= 1'b1;
                    rt_byte  <= byte_in;
                end else if (byte_in == BYTE_SYSEX_START) begin
                    state     <= ST_SYSEX;
                    stat_type <= MSG_NOTE_OFF;
                    stat_chan <= '0;
                end else if (is_syscommon(byte_in)) begin
                    state     <= ST_IDLE;
                    stat_type <= MSG_NOTE_OFF;
                    stat_chan <= '0;
                end else if (byte_in[7]) begin
                    state     <= ST_WAIT_D1;
                    stat_type <= msg_type_t'(byte_in[6:4]);
                    stat_chan <= byte_in[3:0];
                end else begin
                    case (state)
                        ST_WAIT_D1: begin
                            d1_hold <= byte_in[6:0];
                            if (needs_two(stat_type)) begin
                                state <= ST_WAIT_D2;
                            end else if (chan_ok) begin
                                msg_valid <= 1'b1;
                                msg_type  <= emit_type;
                                msg_chan  <= stat_chan;
                                msg_d1    <= emit_d1;
                                msg_d2    <= emit_d2;
                            end
                        end
                        ST_WAIT_D2: begin
                            state <= ST_WAIT_D1;
                            if (chan_ok) begin
                                msg_valid <= 1'b1;
                                msg_type  <= emit_type;
                                msg_chan  <= stat_chan;
                                msg_d1    <= emit_d1;
                                msg_d2    <= emit_d2;
                            end
                        end
                        default: ; // IDLE and SYSEX discard data bytes
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_parser.sv
// Directed bench for midi_parser: an OMNI instance and a channel-2 filtered
// instance share one byte stream and reset.
module tb_midi_parser;

    logic       clk;
    logic       rst_n;
    logic       byte_valid;
    logic [7:0] byte_in;

    logic       a_msg_valid, b_msg_valid;
    logic [2:0] a_msg_type,  b_msg_type;
    logic [3:0] a_msg_chan,  b_msg_chan;
    logic [6:0] a_msg_d1,    b_msg_d1;
    logic [6:0] a_msg_d2,    b_msg_d2;
    logic       a_rt_valid,  b_rt_valid;
    logic [7:0] a_rt_byte,   b_rt_byte;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_a    = 0;
    int cnt_b    = 0;
    int cnt_rt   = 0;
    int base;

    midi_parser dut_a (
        .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_in(byte_in),
        .msg_valid(a_msg_valid), .msg_type(a_msg_type), .msg_chan(a_msg_chan),
        .msg_d1(a_msg_d1), .msg_d2(a_msg_d2),
        .rt_valid(a_rt_valid), .rt_byte(a_rt_byte)
    );

    midi_parser #(.OMNI(1'b0), .CHANNEL(4'd2), .NOTEON_V0_OFF(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_in(byte_in),
        .msg_valid(b_msg_valid), .msg_type(b_msg_type), .msg_chan(b_msg_chan),
        .msg_d1(b_msg_d1), .msg_d2(b_msg_d2),
        .rt_valid(b_rt_valid), .rt_byte(b_rt_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe counters, sampled mid-cycle
    always @(negedge clk) begin
        if (a_msg_valid) cnt_a++;
        if (b_msg_valid) cnt_b++;
        if (a_rt_valid)  cnt_rt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one byte for the following rising edge
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
    endtask

    // Stop driving and sample the cycle after the last byte
    task automatic gap();
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Let strobes drain and counters settle, then move off the negedge
    task automatic settle();
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_msg_valid", a_msg_valid, 0);
        check("rst_msg_type",  a_msg_type,  0);
        check("rst_msg_d1",    a_msg_d1,    0);
        check("rst_rt_valid",  a_rt_valid,  0);
        check("rst_rt_byte",   a_rt_byte,   0);
        rst_n = 1'b1;

        // Basic Note On with one-cycle latency
        send(8'h90); send(8'h3C); send(8'h64);
        check("non_early", a_msg_valid, 0);
        gap();
        check("non_valid", a_msg_valid, 1);
        check("non_type",  a_msg_type,  1);
        check("non_chan",  a_msg_chan,  0);
        check("non_d1",    a_msg_d1,    7'h3C);
        check("non_d2",    a_msg_d2,    7'h64);
        @(negedge clk);
        check("non_held1", a_msg_valid, 0);
        check("non_d1_hold", a_msg_d1, 7'h3C);

        // Running status, velocity 0 becomes Note Off
        send(8'h3E); send(8'h00); gap();
        check("rs_valid", a_msg_valid, 1);
        check("rs_type",  a_msg_type,  0);
        check("rs_d1",    a_msg_d1,    7'h3E);
        check("rs_d2",    a_msg_d2,    0);
        settle();
        check("rs_count", cnt_a, 2);

        // Program Change, running status, back-to-back
        send(8'hC5); send(8'h07); send(8'h08);
        check("pc1_valid", a_msg_valid, 1);
        check("pc1_type",  a_msg_type,  4);
        check("pc1_chan",  a_msg_chan,  5);
        check("pc1_d1",    a_msg_d1,    7'h07);
        check("pc1_d2",    a_msg_d2,    0);
        gap();
        check("pc2_valid", a_msg_valid, 1);
        check("pc2_d1",    a_msg_d1,    7'h08);
        settle();
        check("pc_count", cnt_a, 4);

        // Real-time byte interleaved mid-message
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
        check("rt_valid",  a_rt_valid,  1);
        check("rt_byte",   a_rt_byte,   8'hF8);
        check("rt_nomsg",  a_msg_valid, 0);
        gap();
        check("rt_msg_valid", a_msg_valid, 1);
        check("rt_msg_type",  a_msg_type,  1);
        check("rt_msg_d1",    a_msg_d1,    7'h3C);
        check("rt_msg_d2",    a_msg_d2,    7'h64);
        check("rt_done",      a_rt_valid,  0);
        settle();
        check("rt_count", cnt_rt, 1);

        // SysEx and system common clear running status
        base = cnt_a;
        send(8'hF0); send(8'h12); send(8'h34); send(8'hF7); send(8'h40);
        send(8'hB1); send(8'h07); send(8'hF0); send(8'h01); send(8'hF7);
        send(8'h07); send(8'h7F);
        settle();
        check("sys_nomsg", cnt_a - base, 0);
        check("sys_d1_hold", a_msg_d1, 7'h3C);

        // Data is ignored while byte_valid is low
        base = cnt_a;
        send(8'h90); send(8'h3C);
        @(negedge clk);
        byte_valid = 1'b0;
        byte_in    = 8'h55;
        repeat (3) @(negedge clk);
        send(8'h64); gap();
        check("bv_valid", a_msg_valid, 1);
        check("bv_d1",    a_msg_d1,    7'h3C);
        check("bv_d2",    a_msg_d2,    7'h64);
        settle();
        check("bv_count", cnt_a - base, 1);

        // New status abandons a partial message
        base = cnt_a;
        send(8'h90); send(8'h3C); send(8'h80); send(8'h40); send(8'h00); gap();
        check("ab_type", a_msg_type, 0);
        check("ab_d1",   a_msg_d1,   7'h40);
        settle();
        check("ab_count", cnt_a - base, 1);

        // Pitch Bend on channel 3
        send(8'hE3); send(8'h01); send(8'h7F); gap();
        check("pb_type", a_msg_type, 6);
        check("pb_chan", a_msg_chan, 3);
        check("pb_d2",   a_msg_d2,   7'h7F);
        settle();

        // Channel filter on the CHANNEL=2 instance
        check("flt_none_yet", cnt_b, 0);
        send(8'h91); send(8'h3C); send(8'h64);
        settle();
        check("flt_ch1", cnt_b, 0);
        send(8'h92); send(8'h3C); send(8'h64); gap();
        check("flt_ch2_valid", b_msg_valid, 1);
        check("flt_ch2_chan",  b_msg_chan,  2);
        check("flt_ch2_type",  b_msg_type,  1);
        settle();
        check("flt_ch2_count", cnt_b, 1);

        // Reset mid-message drops the partial message and running status
        base = cnt_a;
        send(8'h92); send(8'h3C);
        @(negedge clk);
        byte_valid = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        check("mrst_valid", b_msg_valid, 0);
        check("mrst_type",  b_msg_type,  0);
        check("mrst_chan",  b_msg_chan,  0);
        check("mrst_d1",    b_msg_d1,    0);
        check("mrst_d2",    b_msg_d2,    0);
        check("mrst_rtbyte", a_rt_byte,  0);
        rst_n = 1'b1;
        send(8'h64);
        settle();
        check("mrst_b_count", cnt_b, 1);
        check("mrst_a_count", cnt_a - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
